// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: AHB3-Lite transfer encodings shared by the master and its bench.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Data access, privileged, non-bufferable, non-cacheable.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/ahb3lite_master.sv
// ahb3lite_master: turns one command (SINGLE or INCR4) into AHB3-Lite transfers
// and reports each completed beat on a one-cycle response strobe.
// Build option: define AHB3LITE_MASTER_INCR4_EN to honour cmd_burst (INCR4);
// without it every command is issued as a SINGLE using beat0 of cmd_wdata.
module ahb3lite_master
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [HADDR_SIZE-1:0]   cmd_addr,
  input  logic [2:0]              cmd_size,
  input  logic                    cmd_burst,
  input  logic [4*HDATA_SIZE-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [HDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    HSEL,
  output logic [HADDR_SIZE-1:0]   HADDR,
  output logic [HDATA_SIZE-1:0]   HWDATA,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic [1:0]              HTRANS,
  input  logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_NSEQ, S_BURST, S_LAST, S_ERR} state_e;

  state_e                  state_q, state_d;
  logic [HADDR_SIZE-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic                    burst_q, burst_d;
  logic [1:0]              beat_q, beat_d;   // beat index of the current address phase
  logic                    rej_q, rej_d;     // previous cycle accepted an illegal command
  logic [4*HDATA_SIZE-1:0] wdata_q, wdata_d;
  logic                    burst_cmd;
  logic [1:0]              dbeat;            // beat index of the current data phase
  logic [HADDR_SIZE-1:0]   addr_inc;

`ifdef AHB3LITE_MASTER_INCR4_EN
  assign burst_cmd = cmd_burst;
`else
  logic unused_cmd_burst;
  assign unused_cmd_burst = cmd_burst;
  assign burst_cmd        = 1'b0;
`endif

  // Sizes above a word and addresses not aligned to the size are refused.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
    case (size)
      3'd0:    cmd_legal = 1'b1;
      3'd1:    cmd_legal = ~addr_lsb[0];
      3'd2:    cmd_legal = (addr_lsb == 2'b00);
      default: cmd_legal = 1'b0;
    endcase
  endfunction

  // Natural modulo-2^HADDR_SIZE wrap of the incrementing burst address.
  assign addr_inc = addr_q + ({{(HADDR_SIZE-1){1'b0}}, 1'b1} << size_q);
  // In BURST the data phase trails the address phase by one beat.
  assign dbeat    = (state_q == S_BURST) ? (beat_q - 2'd1) : beat_q;

  // Control state and bus address/control registers; reset puts the bus idle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      burst_q <= 1'b0;
      beat_q  <= 2'd0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      rej_q   <= rej_d;
    end
  end

  // Write beats are only driven during data phases, so they carry no reset.
  always_ff @(posedge HCLK) begin
    wdata_q <= wdata_d;
  end

  // Next-state logic plus all bus and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    rej_d     = 1'b0;
    wdata_d   = wdata_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    HTRANS    = HTRANS_IDLE;
    HSEL      = 1'b0;
    HWDATA    = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = HRESETn;
        rsp_valid = rej_q;
        rsp_err   = rej_q;
        if (cmd_valid && HRESETn) begin
          if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
            state_d = S_NSEQ;
            addr_d  = cmd_addr;
            write_d = cmd_write;
            size_d  = cmd_size;
            burst_d = burst_cmd;
            beat_d  = 2'd0;
            wdata_d = cmd_wdata;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      S_NSEQ: begin
        HTRANS = HTRANS_NONSEQ;
        HSEL   = 1'b1;
        if (HREADY) begin
          if (burst_q) begin
            state_d = S_BURST;
            addr_d  = addr_inc;
            beat_d  = 2'd1;
          end else begin
            state_d = S_LAST;
          end
        end
      end
      S_BURST, S_LAST: begin
        if (state_q == S_BURST) begin
          HTRANS = HTRANS_SEQ;
          HSEL   = 1'b1;
        end
        HWDATA = wdata_q[dbeat*HDATA_SIZE +: HDATA_SIZE];
        if (HREADY) begin
          rsp_valid = 1'b1;
          rsp_err   = (HRESP != HRESP_OKAY);
          rsp_rdata = write_q ? '0 : HRDATA;
          if (state_q == S_LAST) begin
            state_d = S_IDLE;
          end else if (beat_q == 2'd3) begin
            state_d = S_LAST;
          end else begin
            addr_d = addr_inc;
            beat_d = beat_q + 2'd1;
          end
        end else if (HRESP == HRESP_ERROR) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign HADDR  = addr_q;
  assign HWRITE = write_q;
  assign HSIZE  = size_q;
  assign HBURST = burst_q ? HBURST_INCR4 : HBURST_SINGLE;
  assign HPROT  = HPROT_DEFAULT;

endmodule
